icache_dm: RTL and testbench

//   Direct-mapped, read-only instruction cache. It sits between the processor

---
 rtl/icache_dm_if.sv | 26 ++
 rtl/icache_dm.sv | 140 ++++++++++++++
 tb/tb_icache_dm.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// Fetch-side and ROM-side signals of the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is the CPU/ROM environment.
interface icache_dm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_en;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  flush;
    logic [DATA_WIDTH-1:0] cpu_data;
    logic                  cpu_miss;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_miss;

    modport slave (
        input  cpu_en, cpu_addr, flush, mem_data, mem_miss,
        output cpu_data, cpu_miss, mem_en, mem_addr
    );

    modport master (
        output cpu_en, cpu_addr, flush, mem_data, mem_miss,
        input  cpu_data, cpu_miss, mem_en, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path and a
// two-state refill FSM that streams one whole line from the ROM per miss.
module icache_dm #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    icache_dm_if.slave  bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << (INDEX_BITS + OFFSET_BITS);
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [OFFSET_BITS-1:0]  word_cnt_r, word_cnt_s;
    logic [TAG_W-1:0]        fill_tag_r, fill_tag_s;
    logic [INDEX_BITS-1:0]   fill_idx_r, fill_idx_s;
    logic [LINES-1:0]        valid_r, valid_s;
    logic                    fill_we_s;
    logic                    line_done_s;

    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]   data_mem [WORDS];

    logic [TAG_W-1:0]        cpu_tag_s;
    logic [INDEX_BITS-1:0]   cpu_idx_s;
    logic [OFFSET_BITS-1:0]  cpu_off_s;
    logic                    hit_s;

    assign cpu_tag_s = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign cpu_idx_s = bus.cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign cpu_off_s = bus.cpu_addr[OFFSET_BITS-1:0];

    // A flush cycle never reports a hit, which forces cpu_miss while valids clear.
    assign hit_s = bus.cpu_en & valid_r[cpu_idx_s]
                 & (tag_mem[cpu_idx_s] == cpu_tag_s)
                 & (state_r == IDLE) & ~bus.flush;

    // Fetch-port and ROM-port outputs
    always_comb begin
        bus.cpu_miss = bus.cpu_en & ~hit_s;
        if (hit_s) begin
            bus.cpu_data = data_mem[{cpu_idx_s, cpu_off_s}];
        end else begin
            bus.cpu_data = {DATA_WIDTH{1'b0}};
        end
        if (state_r == REFILL) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = {fill_tag_r, fill_idx_r, word_cnt_r};
        end else begin
            bus.mem_en   = 1'b0;
            bus.mem_addr = {ADDR_WIDTH{1'b0}};
        end
    end

    // Next-state logic for the refill FSM and the valid bits
    always_comb begin
        state_s     = state_r;
        word_cnt_s  = word_cnt_r;
        fill_tag_s  = fill_tag_r;
        fill_idx_s  = fill_idx_r;
        valid_s     = valid_r;
        fill_we_s   = 1'b0;
        line_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.flush) begin
                    valid_s = {LINES{1'b0}};
                end else if (bus.cpu_en & ~hit_s) begin
                    state_s            = REFILL;
                    fill_tag_s         = cpu_tag_s;
                    fill_idx_s         = cpu_idx_s;
                    word_cnt_s         = {OFFSET_BITS{1'b0}};
                    valid_s[cpu_idx_s] = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            REFILL: begin
                if (bus.flush) begin
                    state_s    = IDLE;
                    word_cnt_s = {OFFSET_BITS{1'b0}};
                    valid_s    = {LINES{1'b0}};
                end else if (!bus.mem_miss) begin
                    fill_we_s  = 1'b1;
                    word_cnt_s = word_cnt_r + OFFSET_BITS'(1);
                    if (word_cnt_r == {OFFSET_BITS{1'b1}}) begin
                        state_s             = IDLE;
                        line_done_s         = 1'b1;
                        valid_s[fill_idx_r] = 1'b1;
                    end else begin
                        state_s = REFILL;
                    end
                end else begin
                    state_s = REFILL;
                end
            end
            default: begin
                state_s    = IDLE;
                word_cnt_s = {OFFSET_BITS{1'b0}};
                valid_s    = {LINES{1'b0}};
            end
        endcase
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r    <= IDLE;
            word_cnt_r <= {OFFSET_BITS{1'b0}};
            valid_r    <= {LINES{1'b0}};
            fill_tag_r <= {TAG_W{1'b0}};
            fill_idx_r <= {INDEX_BITS{1'b0}};
        end else begin
            state_r    <= state_s;
            word_cnt_r <= word_cnt_s;
            valid_r    <= valid_s;
            fill_tag_r <= fill_tag_s;
            fill_idx_r <= fill_idx_s;
        end
    end

    // Tag and data arrays are left unreset; the valid bits guard them
    always_ff @(posedge Clk) begin
        if (Rst && fill_we_s) begin
            data_mem[{fill_idx_r, word_cnt_r}] <= bus.mem_data;
        end
        if (Rst && line_done_s) begin
            tag_mem[fill_idx_r] <= fill_tag_r;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios followed by random
// fetches, compared against a line-level presence model of the cache.
module tb_icache_dm;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    icache_dm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    icache_dm dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus)
    );

    // ROM model: every word holds its own address tagged with 0xA in the top nibble
    assign bus.mem_data = 32'hA000_0000 | bus.mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which tag each index currently holds
    bit          ref_valid [64];
    logic [23:0] ref_tag   [64];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic int expected_miss_cycles(input logic [31:0] m);
        int acc = 0;
        int n   = 1;
        for (int j = 0; j < 32 && acc < 4; j++) begin
            n++;
            if (!m[j]) acc++;
        end
        return n;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] mask);
        logic [5:0]  idx;
        logic [23:0] tg;
        bit          exp_hit;
        int          obs;
        int          acc;
        bit          done;
        idx     = a[7:2];
        tg      = a[31:8];
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        bus.cpu_en   = 1'b1;
        bus.cpu_addr = a;
        bus.flush    = 1'b0;
        bus.mem_miss = 1'b0;
        @(negedge clk);
        if (exp_hit) begin
            chk("hit_miss",   {31'd0, bus.cpu_miss}, 32'd0);
            chk("hit_data",   bus.cpu_data, rom_word(a));
            chk("hit_mem_en", {31'd0, bus.mem_en}, 32'd0);
        end else begin
            chk("detect_miss",   {31'd0, bus.cpu_miss}, 32'd1);
            chk("detect_mem_en", {31'd0, bus.mem_en}, 32'd0);
            obs  = 1;
            acc  = 0;
            done = 1'b0;
            for (int j = 0; j < 48 && !done; j++) begin
                @(posedge clk);
                #1 bus.mem_miss = (j < 32) ? mask[j] : 1'b0;
                @(negedge clk);
                if (!bus.cpu_miss) begin
                    done = 1'b1;
                end else begin
                    obs++;
                    chk("refill_mem_en", {31'd0, bus.mem_en}, 32'd1);
                    chk("refill_addr", bus.mem_addr, (a & 32'hFFFF_FFFC) | 32'(acc));
                    if (!bus.mem_miss) acc++;
                end
            end
            bus.mem_miss = 1'b0;
            chk("refill_done",  {31'd0, done}, 32'd1);
            chk("miss_cycles",  32'(obs), 32'(expected_miss_cycles(mask)));
            chk("fill_data",    bus.cpu_data, rom_word(a));
            chk("fill_mem_en",  {31'd0, bus.mem_en}, 32'd0);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic abort_refill(input logic [31:0] a, input bit use_reset);
        bus.cpu_en   = 1'b1;
        bus.cpu_addr = a;
        bus.flush    = 1'b0;
        bus.mem_miss = 1'b0;
        @(negedge clk);
        chk("abort_detect", {31'd0, bus.cpu_miss}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_w0_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        if (use_reset) rst_n = 1'b0;
        else           bus.flush = 1'b1;
        @(negedge clk);
        chk("abort_w1_addr", bus.mem_addr, (a & 32'hFFFF_FFFC) | 32'd1);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        bus.flush  = 1'b0;
        bus.cpu_en = 1'b0;
        @(negedge clk);
        chk("abort_mem_en",   {31'd0, bus.mem_en}, 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'd0);
        chk("abort_cpu_miss", {31'd0, bus.cpu_miss}, 32'd0);
        chk("abort_cpu_data", bus.cpu_data, 32'd0);
        clear_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] m;
        clear_model();
        rst_n        = 1'b0;
        bus.cpu_en   = 1'b0;
        bus.cpu_addr = 32'd0;
        bus.flush    = 1'b0;
        bus.mem_miss = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en",   {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_cpu_miss", {31'd0, bus.cpu_miss}, 32'd0);
        chk("rst_cpu_data", bus.cpu_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Cold miss, hit, conflict eviction
        fetch(32'h0000_0104, 32'd0);
        fetch(32'h0000_0106, 32'd0);
        fetch(32'h0000_0004, 32'd0);
        fetch(32'h0000_0105, 32'd0);

        // ROM stall on the 2nd and 3rd refill cycles
        fetch(32'h0000_0004, 32'd0);
        fetch(32'h0000_0105, 32'h0000_0006);
        fetch(32'h0000_0107, 32'd0);

        // Flush in IDLE
        bus.cpu_en   = 1'b1;
        bus.cpu_addr = 32'h0000_0104;
        bus.flush    = 1'b1;
        @(negedge clk);
        chk("flush_miss",   {31'd0, bus.cpu_miss}, 32'd1);
        chk("flush_data",   bus.cpu_data, 32'd0);
        chk("flush_mem_en", {31'd0, bus.mem_en}, 32'd0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        clear_model();
        fetch(32'h0000_0104, 32'd0);

        // Flush and reset in the middle of a refill
        fetch(32'h0000_0300, 32'd0);
        abort_refill(32'h0000_0204, 1'b0);
        fetch(32'h0000_0300, 32'd0);
        fetch(32'h0000_0204, 32'd0);
        abort_refill(32'h0000_0104, 1'b1);
        fetch(32'h0000_0204, 32'd0);
        fetch(32'h0000_0104, 32'd0);

        // Random fetches over a small set of tags to provoke conflicts
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.cpu_en   = 1'b0;
                bus.cpu_addr = 32'($urandom_range(0, 1023));
                @(negedge clk);
                chk("idle_miss",   {31'd0, bus.cpu_miss}, 32'd0);
                chk("idle_data",   bus.cpu_data, 32'd0);
                chk("idle_mem_en", {31'd0, bus.mem_en}, 32'd0);
                @(posedge clk);
                #1;
            end
            a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2)
              | 32'($urandom_range(0, 3));
            m = $urandom & $urandom & $urandom & 32'h0000_00FF;
            fetch(a, m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
